// File: rtl/layer_merge_buffer.sv
// Double-buffered line merge: resolves sprite layers over a background pixel
// and fills whichever bank the VGA side is not currently reading.
// Handshake: a pixel transfers on a rising edge only when in_valid and in_ready
// are both high; in_ready never depends on in_valid, and the source must hold
// the pixel until it is taken.
module layer_merge_buffer #(
  parameter int PIX_W  = 8,
  parameter int LAYERS = 2,
  parameter int DEPTH  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    readVgaSelector,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [PIX_W-1:0]        R_bg,
  input  logic [PIX_W-1:0]        G_bg,
  input  logic [PIX_W-1:0]        B_bg,
  input  logic [LAYERS*PIX_W-1:0] R_sp,
  input  logic [LAYERS*PIX_W-1:0] G_sp,
  input  logic [LAYERS*PIX_W-1:0] B_sp,
  input  logic [LAYERS-1:0]       sp_en,
  input  logic [PIX_W-1:0]        R_key,
  input  logic [PIX_W-1:0]        G_key,
  input  logic [PIX_W-1:0]        B_key,
  output logic [DEPTH*PIX_W-1:0]  R_outRegA,
  output logic [DEPTH*PIX_W-1:0]  G_outRegA,
  output logic [DEPTH*PIX_W-1:0]  B_outRegA,
  output logic [DEPTH*PIX_W-1:0]  R_outRegB,
  output logic [DEPTH*PIX_W-1:0]  G_outRegB,
  output logic [DEPTH*PIX_W-1:0]  B_outRegB,
  output logic                    full_A,
  output logic                    full_B,
  output logic                    underrun
);

  localparam int             CW   = $clog2(DEPTH);
  localparam logic [CW-1:0]  LAST = CW'(DEPTH - 1);

  logic                        sel_q;
  logic                        swap;
  logic                        tgt_a;
  logic                        tgt_full;
  logic                        vga_full;
  logic                        accept;
  logic [CW-1:0]               cnt_a;
  logic [CW-1:0]               cnt_b;
  logic                        full_a_q;
  logic                        full_b_q;
  logic [DEPTH-1:0][PIX_W-1:0] r_a, g_a, b_a;
  logic [DEPTH-1:0][PIX_W-1:0] r_b, g_b, b_b;
  logic [PIX_W-1:0]            res_r, res_g, res_b;

  // Selector 1 means VGA owns bank B, so bank A is being filled.
  assign swap     = readVgaSelector ^ sel_q;
  assign tgt_a    = readVgaSelector;
  assign tgt_full = tgt_a ? full_a_q : full_b_q;
  assign vga_full = tgt_a ? full_b_q : full_a_q;

  // Both status outputs are forced low while reset is held.
  assign in_ready = reset & ~swap & ~tgt_full;
  assign underrun = reset & swap & ~vga_full;
  assign accept   = in_valid & in_ready;

  assign full_A    = full_a_q;
  assign full_B    = full_b_q;
  assign R_outRegA = r_a;
  assign G_outRegA = g_a;
  assign B_outRegA = b_a;
  assign R_outRegB = r_b;
  assign G_outRegB = g_b;
  assign B_outRegB = b_b;

  // Layer priority: walk from the top index down so the lowest opaque enabled layer wins.
  always_comb begin
    res_r = R_bg;
    res_g = G_bg;
    res_b = B_bg;
    for (int k = LAYERS - 1; k >= 0; k--) begin
      if (sp_en[k] && !(R_sp[k*PIX_W +: PIX_W] == R_key &&
                        G_sp[k*PIX_W +: PIX_W] == G_key &&
                        B_sp[k*PIX_W +: PIX_W] == B_key)) begin
        res_r = R_sp[k*PIX_W +: PIX_W];
        res_g = G_sp[k*PIX_W +: PIX_W];
        res_b = B_sp[k*PIX_W +: PIX_W];
      end
    end
  end

  // Selector history, fill counters and full flags; a swap restarts only the new target.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_q    <= 1'b0;
      cnt_a    <= '0;
      cnt_b    <= '0;
      full_a_q <= 1'b0;
      full_b_q <= 1'b0;
    end else begin
      sel_q <= readVgaSelector;
      if (swap) begin
        if (tgt_a) begin
          cnt_a    <= '0;
          full_a_q <= 1'b0;
        end else begin
          cnt_b    <= '0;
          full_b_q <= 1'b0;
        end
      end else if (accept) begin
        if (tgt_a) begin
          if (cnt_a == LAST) begin
            cnt_a    <= '0;
            full_a_q <= 1'b1;
          end else begin
            cnt_a <= cnt_a + 1'b1;
          end
        end else begin
          if (cnt_b == LAST) begin
            cnt_b    <= '0;
            full_b_q <= 1'b1;
          end else begin
            cnt_b <= cnt_b + 1'b1;
          end
        end
      end
    end
  end

  // Bank storage: the resolved pixel lands at the target bank's current fill index.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a <= '0;
      g_a <= '0;
      b_a <= '0;
      r_b <= '0;
      g_b <= '0;
      b_b <= '0;
    end else if (accept) begin
      if (tgt_a) begin
        r_a[cnt_a] <= res_r;
        g_a[cnt_a] <= res_g;
        b_a[cnt_a] <= res_b;
      end else begin
        r_b[cnt_b] <= res_r;
        g_b[cnt_b] <= res_g;
        b_b[cnt_b] <= res_b;
      end
    end
  end

endmodule

// File: tb/tb_layer_merge_buffer.sv
// Bench for layer_merge_buffer: default instance driven by tables, directed
// sequences and random traffic against a queue-based bank model; a second
// DEPTH=5 / LAYERS=3 instance covers wrap and three-layer priority.
module tb_layer_merge_buffer;

  localparam int PW  = 8;
  localparam int L0N = 2;
  localparam int D0  = 16;
  localparam int L1N = 3;
  localparam int D1  = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  // ---------------- dut0 (defaults) ----------------
  logic              sel0, valid0, ready0;
  logic [PW-1:0]     r_bg0, g_bg0, b_bg0, r_key0, g_key0, b_key0;
  logic [L0N*PW-1:0] r_sp0, g_sp0, b_sp0;
  logic [L0N-1:0]    en0;
  logic [D0*PW-1:0]  ra0, ga0, ba0, rb0, gb0, bb0;
  logic              fa0, fb0, und0;

  layer_merge_buffer dut0 (
    .clk(clk), .reset(reset), .readVgaSelector(sel0),
    .in_valid(valid0), .in_ready(ready0),
    .R_bg(r_bg0), .G_bg(g_bg0), .B_bg(b_bg0),
    .R_sp(r_sp0), .G_sp(g_sp0), .B_sp(b_sp0), .sp_en(en0),
    .R_key(r_key0), .G_key(g_key0), .B_key(b_key0),
    .R_outRegA(ra0), .G_outRegA(ga0), .B_outRegA(ba0),
    .R_outRegB(rb0), .G_outRegB(gb0), .B_outRegB(bb0),
    .full_A(fa0), .full_B(fb0), .underrun(und0)
  );

  // ---------------- dut1 (DEPTH=5, LAYERS=3) ----------------
  logic              sel1, valid1, ready1;
  logic [PW-1:0]     r_bg1, g_bg1, b_bg1, r_key1, g_key1, b_key1;
  logic [L1N*PW-1:0] r_sp1, g_sp1, b_sp1;
  logic [L1N-1:0]    en1;
  logic [D1*PW-1:0]  ra1, ga1, ba1, rb1, gb1, bb1;
  logic              fa1, fb1, und1;

  layer_merge_buffer #(.PIX_W(PW), .LAYERS(L1N), .DEPTH(D1)) dut1 (
    .clk(clk), .reset(reset), .readVgaSelector(sel1),
    .in_valid(valid1), .in_ready(ready1),
    .R_bg(r_bg1), .G_bg(g_bg1), .B_bg(b_bg1),
    .R_sp(r_sp1), .G_sp(g_sp1), .B_sp(b_sp1), .sp_en(en1),
    .R_key(r_key1), .G_key(g_key1), .B_key(b_key1),
    .R_outRegA(ra1), .G_outRegA(ga1), .B_outRegA(ba1),
    .R_outRegB(rb1), .G_outRegB(gb1), .B_outRegB(bb1),
    .full_A(fa1), .full_B(fb1), .underrun(und1)
  );

  // ---------------- scoreboard / model ----------------
  int checks = 0;
  int errors = 0;

  // Pixels written into each bank since its last clear; size == D0 means full.
  logic [23:0] fill_a_q[$];
  logic [23:0] fill_b_q[$];
  logic [23:0] bank_a[D0];
  logic [23:0] bank_b[D0];
  logic        m_sel_q;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic bit m_full(input bit a);
    return a ? (fill_a_q.size() == D0) : (fill_b_q.size() == D0);
  endfunction

  function automatic logic [D0*PW-1:0] pack(input bit a, input int ch);
    logic [D0*PW-1:0] v;
    logic [23:0]      p;
    v = '0;
    for (int i = 0; i < D0; i++) begin
      p = a ? bank_a[i] : bank_b[i];
      v[i*PW +: PW] = p[(2-ch)*8 +: 8];
    end
    return v;
  endfunction

  function automatic logic [23:0] resolve0();
    logic [23:0] key;
    logic [23:0] lay;
    key = {r_key0, g_key0, b_key0};
    for (int k = 0; k < L0N; k++) begin
      lay = {r_sp0[k*PW +: PW], g_sp0[k*PW +: PW], b_sp0[k*PW +: PW]};
      if (en0[k] && lay != key) return lay;
    end
    return {r_bg0, g_bg0, b_bg0};
  endfunction

  task automatic model_reset();
    fill_a_q.delete();
    fill_b_q.delete();
    for (int i = 0; i < D0; i++) begin
      bank_a[i] = '0;
      bank_b[i] = '0;
    end
    m_sel_q = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_px0(input logic [1:0] en, input logic [23:0] l0, input logic [23:0] l1,
                         input logic [23:0] bg);
    en0   = en;
    r_sp0 = {l1[23:16], l0[23:16]};
    g_sp0 = {l1[15:8],  l0[15:8]};
    b_sp0 = {l1[7:0],   l0[7:0]};
    {r_bg0, g_bg0, b_bg0} = bg;
    valid0 = 1'b1;
  endtask

  task automatic px1(input logic [2:0] en, input logic [7:0] v0, input logic [7:0] v1,
                     input logic [7:0] v2, input logic [7:0] bgv);
    en1   = en;
    r_sp1 = {v2, v1, v0};
    g_sp1 = {v2, v1, v0};
    b_sp1 = {v2, v1, v0};
    r_bg1 = bgv;
    g_bg1 = bgv;
    b_bg1 = bgv;
    valid1 = 1'b1;
  endtask

  // Called at posedge+1 with dut0 inputs already set; returns at the next posedge+1.
  task automatic step();
    bit          swap, tgt_a, exp_ready, exp_und;
    logic [23:0] pix;
    #2;
    swap      = (sel0 != m_sel_q);
    tgt_a     = sel0;
    exp_ready = !swap && !m_full(tgt_a);
    exp_und   = swap && !m_full(!tgt_a);
    chk("in_ready", ready0, exp_ready);
    chk("underrun", und0, exp_und);
    @(posedge clk);
    if (swap) begin
      if (tgt_a) fill_a_q.delete();
      else       fill_b_q.delete();
    end else if (valid0 && exp_ready) begin
      pix = resolve0();
      if (tgt_a) begin
        bank_a[fill_a_q.size()] = pix;
        fill_a_q.push_back(pix);
      end else begin
        bank_b[fill_b_q.size()] = pix;
        fill_b_q.push_back(pix);
      end
    end
    m_sel_q = sel0;
    #1;
    chk("full_A", fa0, m_full(1'b1));
    chk("full_B", fb0, m_full(1'b0));
    chk("R_outRegA", ra0, pack(1'b1, 0));
    chk("G_outRegA", ga0, pack(1'b1, 1));
    chk("B_outRegA", ba0, pack(1'b1, 2));
    chk("R_outRegB", rb0, pack(1'b0, 0));
    chk("G_outRegB", gb0, pack(1'b0, 1));
    chk("B_outRegB", bb0, pack(1'b0, 2));
  endtask

  task automatic do_reset(input logic s);
    reset  = 1'b0;
    sel0   = s;
    valid0 = 1'b0;
    sel1   = 1'b0;
    valid1 = 1'b0;
    model_reset();
    @(posedge clk);
    #2;
    chk("rst_in_ready", ready0, 0);
    chk("rst_underrun", und0, 0);
    chk("rst_full_A", fa0, 0);
    chk("rst_full_B", fb0, 0);
    chk("rst_R_outRegA", ra0, 0);
    chk("rst_R_outRegB", rb0, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  function automatic logic [23:0] pick_layer(input logic [23:0] key);
    int          r;
    logic [23:0] m;
    r = $urandom_range(0, 3);
    m = 24'h0000FF;
    if (r == 0) return key;
    if (r == 1) return key ^ (m << (8 * $urandom_range(0, 2)));
    return 24'($urandom);
  endfunction

  // ---------------- resolution vectors ----------------
  typedef struct {
    logic [1:0]  en;
    logic [23:0] l0;
    logic [23:0] l1;
    logic [23:0] bg;
    logic [23:0] exp;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [23:0] rec[5];
    logic [39:0] exp1;
    logic [7:0]  exp1_px[5];

    tbl[0] = '{2'b11, 24'h171717, 24'hAAAAAA, 24'h102030, 24'hAAAAAA};
    tbl[1] = '{2'b11, 24'h555555, 24'hAAAAAA, 24'h102030, 24'h555555};
    tbl[2] = '{2'b00, 24'h555555, 24'hAAAAAA, 24'h102030, 24'h102030};
    tbl[3] = '{2'b10, 24'h555555, 24'hAAAAAA, 24'h102030, 24'hAAAAAA};
    tbl[4] = '{2'b01, 24'h171717, 24'hAAAAAA, 24'h0A0B0C, 24'h0A0B0C};
    tbl[5] = '{2'b11, 24'h171718, 24'hAAAAAA, 24'h102030, 24'h171718};
    tbl[6] = '{2'b11, 24'h171717, 24'h171717, 24'h0A0B0C, 24'h0A0B0C};
    tbl[7] = '{2'b11, 24'h177717, 24'hAAAAAA, 24'h102030, 24'h177717};

    {r_key0, g_key0, b_key0} = 24'h171717;
    {r_key1, g_key1, b_key1} = 24'h171717;
    set_px0(2'b00, 24'h0, 24'h0, 24'h0);
    valid0 = 1'b0;
    px1(3'b000, 8'h0, 8'h0, 8'h0, 8'h0);
    valid1 = 1'b0;
    sel0 = 1'b0;
    sel1 = 1'b0;

    // Priority / key table into bank B.
    do_reset(1'b0);
    for (int i = 0; i < 8; i++) begin
      set_px0(tbl[i].en, tbl[i].l0, tbl[i].l1, tbl[i].bg);
      step();
    end
    valid0 = 1'b0;
    for (int i = 0; i < 8; i++)
      chk($sformatf("tbl_pix%0d", i), {rb0[i*8 +: 8], gb0[i*8 +: 8], bb0[i*8 +: 8]}, tbl[i].exp);

    // Full fill of bank B with a flat background.
    do_reset(1'b0);
    for (int i = 0; i < D0; i++) begin
      set_px0(2'b00, 24'h0, 24'h0, 24'h102030);
      step();
    end
    chk("fill16_R_B", rb0, {16{8'h10}});
    chk("fill16_full_B", fb0, 1);
    chk("fill16_ready_low", ready0, 0);
    step();
    chk("fill16_hold_G_B", gb0, {16{8'h20}});
    valid0 = 1'b0;

    // Swap after five pixels into B.
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) begin
      rec[i] = {8'(i + 1), 8'(i + 8'h41), 8'(i + 8'h81)};
      set_px0(2'b00, 24'h0, 24'h0, rec[i]);
      step();
    end
    sel0 = 1'b1;
    #2;
    chk("swap_ready", ready0, 0);
    chk("swap_underrun", und0, 1);
    chk("swap_full_A", fa0, 0);
    step();
    for (int i = 0; i < 5; i++)
      chk($sformatf("swap_keepB%0d", i), {rb0[i*8 +: 8], gb0[i*8 +: 8], bb0[i*8 +: 8]}, rec[i]);
    set_px0(2'b00, 24'h0, 24'h0, 24'hC1C2C3);
    step();
    chk("swap_A_idx0", {ra0[7:0], ga0[7:0], ba0[7:0]}, 24'hC1C2C3);
    chk("swap_underrun_gone", und0, 0);
    valid0 = 1'b0;

    // Idle gap mid-fill.
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) begin
      set_px0(2'b00, 24'h0, 24'h0, 24'h111111 * (i + 1));
      step();
    end
    valid0 = 1'b0;
    repeat (3) step();
    set_px0(2'b00, 24'h0, 24'h0, 24'h5A5A5A);
    step();
    chk("gap_idx4", rb0[4*8 +: 8], 8'h5A);
    chk("gap_idx5_empty", rb0[5*8 +: 8], 8'h00);
    valid0 = 1'b0;

    // Asynchronous reset between edges at count 9.
    do_reset(1'b0);
    for (int i = 0; i < 9; i++) begin
      set_px0(2'b00, 24'h0, 24'h0, 24'h313233);
      step();
    end
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk("areset_R_B", rb0, 0);
    chk("areset_G_B", gb0, 0);
    chk("areset_ready", ready0, 0);
    chk("areset_full_B", fb0, 0);
    valid0 = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    set_px0(2'b00, 24'h0, 24'h0, 24'h7E7E7E);
    step();
    chk("areset_idx0", rb0[7:0], 8'h7E);
    chk("areset_idx1", rb0[15:8], 8'h00);
    valid0 = 1'b0;

    // Selector already 1 at reset release: first cycle is a swap.
    do_reset(1'b1);
    #2;
    chk("first_swap_underrun", und0, 1);
    chk("first_swap_ready", ready0, 0);
    step();
    chk("first_swap_done", und0, 0);

    // Random traffic against the model.
    do_reset(1'b0);
    {r_key0, g_key0, b_key0} = 24'($urandom);
    for (int c = 0; c < 1200; c++) begin
      if ($urandom_range(0, 29) == 0) sel0 = ~sel0;
      set_px0(2'($urandom), pick_layer({r_key0, g_key0, b_key0}),
              pick_layer({r_key0, g_key0, b_key0}), 24'($urandom));
      valid0 = ($urandom_range(0, 3) != 0);
      step();
    end
    valid0 = 1'b0;
    sel0 = 1'b0;

    // DEPTH=5 / LAYERS=3 instance.
    do_reset(1'b0);
    exp1_px = '{8'h33, 8'h11, 8'h22, 8'h44, 8'h44};
    exp1 = '0;
    for (int i = 0; i < D1; i++) exp1[i*8 +: 8] = exp1_px[i];
    for (int i = 0; i < D1; i++) begin
      case (i)
        0: px1(3'b111, 8'h17, 8'h17, 8'h33, 8'h44);
        1: px1(3'b111, 8'h11, 8'h22, 8'h33, 8'h44);
        2: px1(3'b110, 8'h11, 8'h22, 8'h33, 8'h44);
        3: px1(3'b100, 8'h11, 8'h22, 8'h17, 8'h44);
        default: px1(3'b011, 8'h17, 8'h17, 8'h33, 8'h44);
      endcase
      #2;
      chk($sformatf("d5_ready%0d", i), ready1, 1);
      @(posedge clk);
      #1;
    end
    chk("d5_full_B", fb1, 1);
    chk("d5_ready_low", ready1, 0);
    chk("d5_R_B", rb1, exp1);
    chk("d5_B_B", bb1, exp1);
    px1(3'b111, 8'h99, 8'h99, 8'h99, 8'h99);
    repeat (2) @(posedge clk);
    #1;
    chk("d5_no_overwrite", rb1, exp1);
    valid1 = 1'b0;
    sel1 = 1'b1;
    #2;
    chk("d5_swapA_underrun", und1, 0);
    @(posedge clk);
    #1;
    chk("d5_swapA_keep_full_B", fb1, 1);
    chk("d5_swapA_keep_B", rb1, exp1);
    chk("d5_swapA_full_A", fa1, 0);
    sel1 = 1'b0;
    #2;
    chk("d5_swapB_underrun", und1, 1);
    @(posedge clk);
    #1;
    chk("d5_swapB_full_B", fb1, 0);
    px1(3'b111, 8'h99, 8'h17, 8'h17, 8'h44);
    @(posedge clk);
    #1;
    valid1 = 1'b0;
    chk("d5_idx0_rewrite", rb1[7:0], 8'h99);
    chk("d5_rest_kept", rb1[39:8], exp1[39:8]);
    chk("d5_not_full", fb1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
